vga_scanout: RTL and testbench

- Downstream consumer of the 2-D frame-buffer RAM.
- Generates VGA horizontal and vertical timing, and drives the RAM read row/column address from the beam position.
- Captures the combinational read data and emits registered RGB, hsync, vsync and data-enable to the DAC/pins.
- Supports integer pixel replication (power-of-two), so a small buffer can fill a 640x480 screen.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_timing_counter.sv | 46 ++++
 rtl/vga_scanout.sv | 129 ++++++++++++
 tb/tb_vga_scanout.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, polarity type and frame-total helper.
package vga_pkg;

  // Asserted level of hsync / vsync.
  typedef logic sync_pol_t;

  localparam sync_pol_t SYNC_ACTIVE_LOW  = 1'b0;
  localparam sync_pol_t SYNC_ACTIVE_HIGH = 1'b1;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock.
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  // Total period of one axis (pixels per line or lines per frame).
  function automatic int vga_total(input int visible, input int front,
                                   input int sync, input int back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// One axis of the VGA beam: a wrapping position counter plus decoded
// visible-area, sync-window and wrap flags (all combinational from the count).
module vga_timing_counter #(
  parameter int unsigned TOTAL      = 800,
  parameter int unsigned VISIBLE    = 640,
  parameter int unsigned SYNC_START = 656,
  parameter int unsigned SYNC_LEN   = 96,
  localparam int W = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_visible,
  output logic         o_sync,
  output logic         o_wrap
);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;
  logic [31:0]  count_ext;

  assign count_ext = 32'(count_reg);
  assign o_count   = count_reg;
  assign o_wrap    = (count_ext == TOTAL - 1);
  assign o_visible = (count_ext < VISIBLE);
  assign o_sync    = (count_ext >= SYNC_START) && (count_ext < SYNC_START + SYNC_LEN);

  // Next position: advance on increment, wrapping at the last position of the period.
  always_comb begin
    count_next = count_reg;
    if (i_inc) begin
      count_next = o_wrap ? '0 : count_reg + W'(1);
    end
  end

  // Position register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: beam timing, frame-buffer read addressing with power-of-two
// pixel replication, and one registered output stage toward the DAC.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int        WordSize    = 8,
  parameter int        Rows_Bus    = 10,
  parameter int        Columns_Bus = 10,
  parameter int        SCALE_SHIFT = 0,
  parameter int        H_VISIBLE   = VGA_H_VISIBLE,
  parameter int        H_FRONT     = VGA_H_FRONT,
  parameter int        H_SYNC      = VGA_H_SYNC,
  parameter int        H_BACK      = VGA_H_BACK,
  parameter int        V_VISIBLE   = VGA_V_VISIBLE,
  parameter int        V_FRONT     = VGA_V_FRONT,
  parameter int        V_SYNC      = VGA_V_SYNC,
  parameter int        V_BACK      = VGA_V_BACK,
  parameter sync_pol_t SYNC_ACTIVE = SYNC_ACTIVE_LOW
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_pix_en,
  output logic [Rows_Bus-1:0]    o_raddr_row,
  output logic [Columns_Bus-1:0] o_raddr_col,
  input  logic [WordSize-1:0]    i_rdata,
  output logic [WordSize-1:0]    o_rgb,
  output logic                   o_de,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic                   o_frame_start
);

  localparam int H_TOTAL = vga_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = vga_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int H_W     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int V_W     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic           h_visible, h_sync, h_wrap;
  logic           v_visible, v_sync, v_wrap;
  logic           v_inc;

  // Vertical axis steps once per completed line.
  assign v_inc = h_wrap & i_pix_en;

  vga_timing_counter #(
    .TOTAL     (H_TOTAL),
    .VISIBLE   (H_VISIBLE),
    .SYNC_START(H_VISIBLE + H_FRONT),
    .SYNC_LEN  (H_SYNC)
  ) u_h_counter (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_inc    (i_pix_en),
    .o_count  (h_cnt),
    .o_visible(h_visible),
    .o_sync   (h_sync),
    .o_wrap   (h_wrap)
  );

  vga_timing_counter #(
    .TOTAL     (V_TOTAL),
    .VISIBLE   (V_VISIBLE),
    .SYNC_START(V_VISIBLE + V_FRONT),
    .SYNC_LEN  (V_SYNC)
  ) u_v_counter (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_inc    (v_inc),
    .o_count  (v_cnt),
    .o_visible(v_visible),
    .o_sync   (v_sync),
    .o_wrap   (v_wrap)
  );

  // Buffer coordinates: screen position divided by the replication factor.
  // Upper bits beyond the address width mark positions past the buffer edge.
  logic [31:0] h_scaled, v_scaled;
  logic        visible, inbuf;

  assign h_scaled    = 32'(h_cnt) >> SCALE_SHIFT;
  assign v_scaled    = 32'(v_cnt) >> SCALE_SHIFT;
  assign o_raddr_col = h_scaled[Columns_Bus-1:0];
  assign o_raddr_row = v_scaled[Rows_Bus-1:0];

  assign visible = h_visible & v_visible;
  assign inbuf   = visible
                 & ((h_scaled >> Columns_Bus) == 32'd0)
                 & ((v_scaled >> Rows_Bus) == 32'd0);

  // Pixel blanked to black outside the buffer or outside the visible area.
  logic [WordSize-1:0] rgb_next;
  genvar gi;
  generate
    for (gi = 0; gi < WordSize; gi++) begin : g_rgb_mask
      assign rgb_next[gi] = i_rdata[gi] & inbuf;
    end
  endgenerate

  logic [WordSize-1:0] rgb_reg;
  logic                de_reg, hsync_reg, vsync_reg, frame_start_reg;

  // Output stage: one pixel tick behind the counters; holds while the enable is low.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rgb_reg         <= '0;
      de_reg          <= 1'b0;
      hsync_reg       <= ~SYNC_ACTIVE;
      vsync_reg       <= ~SYNC_ACTIVE;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= i_pix_en && (h_cnt == '0) && (v_cnt == '0);
      if (i_pix_en) begin
        rgb_reg   <= rgb_next;
        de_reg    <= visible;
        hsync_reg <= h_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_reg <= v_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      end
    end
  end

  assign o_rgb         = rgb_reg;
  assign o_de          = de_reg;
  assign o_hsync       = hsync_reg;
  assign o_vsync       = vsync_reg;
  assign o_frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout. Two instances share clock, reset and enable:
//   dut   : H 8/2/3/1 (14/line), V 4/1/1/1 (7 lines, 98/frame), no scaling,
//           RAM model returns {row[3:0], col[3:0]}.
//   dut_s : H 12/2/3/1, V 4/1/1/1, SCALE_SHIFT=1, 2-bit addresses,
//           RAM model returns {4'hA, row[1:0], col[1:0]}.
// After a sample at index s (counting enabled ticks from reset release),
// the outputs of dut show beam state s: h = s % 14, v = (s / 14) % 7.
module tb_vga_scanout;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_en = 1'b0;

  logic [9:0] raddr_row, raddr_col;
  logic [7:0] rdata, rgb;
  logic       de, hsync, vsync, frame_start;

  logic [1:0] raddr_row_s, raddr_col_s;
  logic [7:0] rdata_s, rgb_s;
  logic       de_s, hsync_s, vsync_s, frame_start_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rdata   = {raddr_row[3:0], raddr_col[3:0]};
  assign rdata_s = {4'hA, raddr_row_s, raddr_col_s};

  vga_scanout #(
    .WordSize(8), .Rows_Bus(10), .Columns_Bus(10), .SCALE_SHIFT(0),
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_ACTIVE(1'b0)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_pix_en(pix_en),
    .o_raddr_row(raddr_row), .o_raddr_col(raddr_col), .i_rdata(rdata),
    .o_rgb(rgb), .o_de(de), .o_hsync(hsync), .o_vsync(vsync),
    .o_frame_start(frame_start)
  );

  vga_scanout #(
    .WordSize(8), .Rows_Bus(2), .Columns_Bus(2), .SCALE_SHIFT(1),
    .H_VISIBLE(12), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_ACTIVE(1'b0)
  ) dut_s (
    .i_clk(clk), .i_rst(rst), .i_pix_en(pix_en),
    .o_raddr_row(raddr_row_s), .o_raddr_col(raddr_col_s), .i_rdata(rdata_s),
    .o_rgb(rgb_s), .o_de(de_s), .o_hsync(hsync_s), .o_vsync(vsync_s),
    .o_frame_start(frame_start_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves both DUTs at beam (0,0) with reset released and no enabled edge yet.
  task automatic do_reset();
    rst = 1'b1;
    pix_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pix_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({hsync, vsync, de, frame_start} !== 4'b1100) begin
        n_err++;
        $display("FAIL reset_ctrl[%0d]: got hs/vs/de/fs=%b required 1100", i, {hsync, vsync, de, frame_start});
      end
      n_vec++;
      if ({rgb, raddr_row, raddr_col} !== 28'd0) begin
        n_err++;
        $display("FAIL reset_data[%0d]: got rgb=%0h row=%0d col=%0d required all 0", i, rgb, raddr_row, raddr_col);
      end
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (frame_start !== 1'b1) begin
      n_err++;
      $display("FAIL reset_first_fs: got %b required 1", frame_start);
    end
    n_vec++;
    if ({de, rgb} !== 9'h100) begin
      n_err++;
      $display("FAIL reset_first_pix: got de=%b rgb=%0h required de=1 rgb=0", de, rgb);
    end
    tick();
    n_vec++;
    if (frame_start !== 1'b0) begin
      n_err++;
      $display("FAIL reset_fs_width: got %b required 0", frame_start);
    end
    $display("test_reset done");
  endtask

  task automatic test_timing();
    int hs_fall[$];
    int vs_fall[$];
    int fs_at[$];
    int hs_low_line0 = 0;
    int vs_low_frame = 0;
    int de_line0 = 0;
    logic hs_prev = 1'b1;
    logic vs_prev = 1'b1;
    do_reset();
    for (int s = 0; s < 120; s++) begin
      tick();
      if (hs_prev && !hsync) hs_fall.push_back(s);
      if (vs_prev && !vsync) vs_fall.push_back(s);
      if (frame_start) fs_at.push_back(s);
      if (s < 14 && !hsync) hs_low_line0++;
      if (s < 14 && de) de_line0++;
      if (s < 98 && !vsync) vs_low_frame++;
      hs_prev = hsync;
      vs_prev = vsync;
    end
    n_vec++;
    if (hs_fall.size() < 2 || hs_fall[0] != 10 || hs_fall[1] - hs_fall[0] != 14) begin
      n_err++;
      $display("FAIL hsync_start_period: got falls=%p required first 10, period 14", hs_fall);
    end
    n_vec++;
    if (hs_low_line0 != 3) begin
      n_err++;
      $display("FAIL hsync_width: got %0d required 3", hs_low_line0);
    end
    n_vec++;
    if (de_line0 != 8) begin
      n_err++;
      $display("FAIL de_per_line: got %0d required 8", de_line0);
    end
    n_vec++;
    if (vs_fall.size() < 1 || vs_fall[0] != 70) begin
      n_err++;
      $display("FAIL vsync_start: got falls=%p required first 70", vs_fall);
    end
    n_vec++;
    if (vs_low_frame != 14) begin
      n_err++;
      $display("FAIL vsync_width: got %0d required 14", vs_low_frame);
    end
    n_vec++;
    if (fs_at.size() != 2 || fs_at[0] != 0 || fs_at[1] != 98) begin
      n_err++;
      $display("FAIL frame_period: got pulses=%p required 0 and 98", fs_at);
    end
    $display("test_timing done");
  endtask

  task automatic test_datapath();
    do_reset();
    for (int s = 0; s < 60; s++) begin
      tick();
      if (s == 32) begin
        n_vec++;
        if (raddr_row !== 10'd2 || raddr_col !== 10'd5) begin
          n_err++;
          $display("FAIL addr_5_2: got row=%0d col=%0d required row=2 col=5", raddr_row, raddr_col);
        end
      end
      if (s == 33) begin
        n_vec++;
        if (rgb !== 8'h25 || de !== 1'b1) begin
          n_err++;
          $display("FAIL pix_5_2: got rgb=%0h de=%b required 25/1", rgb, de);
        end
      end
      if (s == 37) begin
        n_vec++;
        if (rgb !== 8'h00 || de !== 1'b0) begin
          n_err++;
          $display("FAIL hblank_9_2: got rgb=%0h de=%b required 0/0", rgb, de);
        end
      end
      if (s == 59) begin
        n_vec++;
        if (rgb !== 8'h00 || de !== 1'b0) begin
          n_err++;
          $display("FAIL vblank_3_4: got rgb=%0h de=%b required 0/0", rgb, de);
        end
      end
    end
    $display("test_datapath done");
  endtask

  task automatic test_scaling();
    logic [1:0] exp_col [12];
    logic [7:0] exp_rgb [12];
    exp_col = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1};
    exp_rgb = '{8'hA0, 8'hA0, 8'hA1, 8'hA1, 8'hA2, 8'hA2, 8'hA3, 8'hA3,
                8'h00, 8'h00, 8'h00, 8'h00};
    do_reset();
    for (int h = 0; h < 12; h++) begin
      n_vec++;
      if (raddr_col_s !== exp_col[h] || raddr_row_s !== 2'd0) begin
        n_err++;
        $display("FAIL scale_addr h=%0d: got row=%0d col=%0d required row=0 col=%0d", h, raddr_row_s, raddr_col_s, exp_col[h]);
      end
      tick();
      n_vec++;
      if (rgb_s !== exp_rgb[h] || de_s !== 1'b1) begin
        n_err++;
        $display("FAIL scale_pix h=%0d: got rgb=%0h de=%b required %0h/1", h, rgb_s, de_s, exp_rgb[h]);
      end
    end
    $display("test_scaling done");
  endtask

  task automatic test_enable();
    do_reset();
    pix_en = 1'b1;
    tick();
    n_vec++;
    if (frame_start !== 1'b1 || raddr_col !== 10'd1) begin
      n_err++;
      $display("FAIL en_first: got fs=%b col=%0d required 1/1", frame_start, raddr_col);
    end
    pix_en = 1'b0;
    tick();
    n_vec++;
    if (frame_start !== 1'b0 || raddr_col !== 10'd1 || rgb !== 8'h00 || de !== 1'b1) begin
      n_err++;
      $display("FAIL en_hold0: got fs=%b col=%0d rgb=%0h de=%b required 0/1/0/1", frame_start, raddr_col, rgb, de);
    end
    pix_en = 1'b1;
    tick();
    n_vec++;
    if (frame_start !== 1'b0 || raddr_col !== 10'd2 || rgb !== 8'h01) begin
      n_err++;
      $display("FAIL en_step1: got fs=%b col=%0d rgb=%0h required 0/2/01", frame_start, raddr_col, rgb);
    end
    pix_en = 1'b0;
    tick();
    n_vec++;
    if (raddr_col !== 10'd2 || rgb !== 8'h01 || de !== 1'b1) begin
      n_err++;
      $display("FAIL en_hold1: got col=%0d rgb=%0h de=%b required 2/01/1", raddr_col, rgb, de);
    end
    pix_en = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    pix_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (hsync !== 1'b0 || raddr_col !== 10'd11 || frame_start !== 1'b0) begin
        n_err++;
        $display("FAIL en_hold_sync[%0d]: got hs=%b col=%0d fs=%b required 0/11/0", i, hsync, raddr_col, frame_start);
      end
    end
    pix_en = 1'b1;
    tick();
    n_vec++;
    if (hsync !== 1'b0 || raddr_col !== 10'd12) begin
      n_err++;
      $display("FAIL en_resume: got hs=%b col=%0d required 0/12", hsync, raddr_col);
    end
    $display("test_enable done");
  endtask

  task automatic test_mid_reset();
    int fs_at[$];
    int hs_first = -1;
    do_reset();
    for (int s = 0; s < 82; s++) tick();
    n_vec++;
    if (hsync !== 1'b0 || vsync !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_pre: got hs=%b vs=%b required 0/0", hsync, vsync);
    end
    rst = 1'b1;
    tick();
    n_vec++;
    if ({hsync, vsync, de, frame_start} !== 4'b1100 || raddr_row !== 10'd0 || raddr_col !== 10'd0) begin
      n_err++;
      $display("FAIL midrst_state: got hs/vs/de/fs=%b row=%0d col=%0d required 1100/0/0", {hsync, vsync, de, frame_start}, raddr_row, raddr_col);
    end
    rst = 1'b0;
    for (int k = 0; k < 110; k++) begin
      tick();
      if (frame_start) fs_at.push_back(k);
      if (hs_first < 0 && !hsync) hs_first = k;
    end
    n_vec++;
    if (fs_at.size() != 2 || fs_at[0] != 0 || fs_at[1] != 98) begin
      n_err++;
      $display("FAIL midrst_frame: got pulses=%p required 0 and 98", fs_at);
    end
    n_vec++;
    if (hs_first != 10) begin
      n_err++;
      $display("FAIL midrst_hsync: got first low at %0d required 10", hs_first);
    end
    $display("test_mid_reset done");
  endtask

  initial begin
    test_reset();
    test_timing();
    test_datapath();
    test_scaling();
    test_enable();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
